// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encoding
// and default build-time sizes.
// No logic; imported by the generator top and by its interface users.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_REPEAT_W = 4;

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Load handshake and serial output bundle of serial_pattern_gen.
// master: upstream/consumer side (drives load_*, observes dout/status).
// slave : the generator (accepts load_*, drives dout/status).
// SERIAL_PATTERN_GEN_EXPECT_EN adds expect_out to the bundle.
interface serial_pattern_gen_if #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4
);

  logic                load_valid;
  logic                load_ready;
  logic [WIDTH-1:0]    load_data;
  logic [REPEAT_W-1:0] load_repeat;
  logic                dout;
  logic                dout_valid;
  logic                busy;
  logic                done;
`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
  logic                expect_out;

  modport master (
    output load_valid, load_data, load_repeat,
    input  load_ready, dout, dout_valid, busy, done, expect_out
  );

  modport slave (
    input  load_valid, load_data, load_repeat,
    output load_ready, dout, dout_valid, busy, done, expect_out
  );
`else
  modport master (
    output load_valid, load_data, load_repeat,
    input  load_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_repeat,
    output load_ready, dout, dout_valid, busy, done
  );
`endif

endinterface

// File: rtl/serial_pattern_gen_window_2of3_model.sv
// 2-of-3 majority window over the transmitted bit stream (expected detector output).
// Latency: expect_bit is registered on the same edge that registers the bit it covers.
// No backpressure; history advances only on bit_valid cycles and is cleared only by reset.
// Ports: clk, reset (sync, active-high), data_bit/bit_valid (bit being registered
// onto dout this edge), expect_bit (registered majority result).
module window_2of3_model (
  input  logic clk,
  input  logic reset,
  input  logic data_bit,
  input  logic bit_valid,
  output logic expect_bit
);

  // hist[0] = most recently transmitted bit, hist[1] = the one before it
  logic [1:0] hist;
  logic       majority;

  always_comb begin
    majority = (data_bit & hist[0]) | (data_bit & hist[1]) | (hist[0] & hist[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist       <= 2'b00;
      expect_bit <= 1'b0;
    end else begin
      expect_bit <= bit_valid & majority;
      if (bit_valid) begin
        hist <= {hist[0], data_bit};
      end
    end
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern source: shifts a loaded word out MSB-first, repeated load_repeat+1 times.
// Latency: first bit on dout the cycle after the accepting edge; done one cycle after the last bit.
// Backpressure: load_ready is high only in IDLE; offers during SHIFT/DONE wait upstream.
// Ports: clk, reset (sync, active-high), bus (serial_pattern_gen_if.slave: load_valid/
// load_ready/load_data/load_repeat, dout/dout_valid, busy, done).
// Optional: SERIAL_PATTERN_GEN_EXPECT_EN adds bus.expect_out (2-of-3 window on sent bits).
module serial_pattern_gen
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int REPEAT_W = DEFAULT_REPEAT_W
) (
  input logic              clk,
  input logic              reset,
  serial_pattern_gen_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    shift_reg, shift_nxt;
  logic [WIDTH-1:0]    pattern, pattern_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [REPEAT_W-1:0] rep_cnt, rep_cnt_nxt;

  logic dout_r, dout_nxt;
  logic valid_r, valid_nxt;
  logic busy_r, busy_nxt;
  logic done_r, done_nxt;
  logic ready_r, ready_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      pattern   <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      dout_r    <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      pattern   <= pattern_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rep_cnt   <= rep_cnt_nxt;
      dout_r    <= dout_nxt;
      valid_r   <= valid_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      ready_r   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    pattern_nxt = pattern;
    bit_cnt_nxt = bit_cnt;
    rep_cnt_nxt = rep_cnt;

    case (state)
      IDLE: begin
        if (bus.load_valid && ready_r) begin
          state_nxt   = SHIFT;
          shift_nxt   = bus.load_data;
          pattern_nxt = bus.load_data;
          rep_cnt_nxt = bus.load_repeat;
          bit_cnt_nxt = LAST_BIT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (rep_cnt != '0) begin
            // Reload in the same edge so repetitions run back to back.
            shift_nxt   = pattern;
            bit_cnt_nxt = LAST_BIT;
            rep_cnt_nxt = rep_cnt - 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          shift_nxt   = shift_reg << 1;
          bit_cnt_nxt = bit_cnt - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered as a function of the state being entered, so
  // dout always equals shift_reg[WIDTH-1] while in SHIFT.
  always_comb begin
    dout_nxt  = 1'b0;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    ready_nxt = 1'b0;
    case (state_nxt)
      SHIFT: begin
        dout_nxt  = shift_nxt[WIDTH-1];
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        ready_nxt = 1'b1;
      end
    endcase
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.load_ready = ready_r;

`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
  logic expect_r;

  // Fed with the next-cycle dout so expect_out lines up with dout.
  window_2of3_model u_window (
    .clk        (clk),
    .reset      (reset),
    .data_bit   (dout_nxt),
    .bit_valid  (valid_nxt),
    .expect_bit (expect_r)
  );

  assign bus.expect_out = expect_r;
`endif

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: directed bursts plus random
// bursts, checked against a bit-list reference model built from the word,
// repeat count and MSB-first ordering.
module tb_serial_pattern_gen;

  localparam int W  = 8;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_pattern_gen_if #(.WIDTH(W), .REPEAT_W(RW)) bus ();

  serial_pattern_gen #(.WIDTH(W), .REPEAT_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Every bit transmitted since the last reset (reference for the 2-of-3 window).
  logic tx_q[$];
  logic [7:0] exp_obs;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic window_ref(input logic b);
    int ones;
    ones = int'(b);
    if (tx_q.size() >= 1) ones += int'(tx_q[tx_q.size()-1]);
    if (tx_q.size() >= 2) ones += int'(tx_q[tx_q.size()-2]);
    return ones >= 2;
  endfunction

  task automatic chk_idle(input string tag);
    chk(tag, {bus.load_ready, bus.busy, bus.done, bus.dout_valid, bus.dout}, 5'b10000);
`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
    chk({tag, "_expect"}, bus.expect_out, 1'b0);
`endif
  endtask

  task automatic chk_bit(input logic b);
    chk("bit_dout", bus.dout, b);
    chk("bit_ctl", {bus.load_ready, bus.busy, bus.done, bus.dout_valid}, 4'b0101);
`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
    chk("bit_expect", bus.expect_out, window_ref(b));
    exp_obs = {exp_obs[6:0], bus.expect_out};
`endif
    tx_q.push_back(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk_idle("reset_state");
    reset = 1'b0;
    tx_q.delete();
  endtask

  // Offer a word and wait (bounded) for the accepting edge; afterwards the
  // current sample shows the first bit. Inputs are scrambled after transfer.
  task automatic accept(input logic [W-1:0] data, input logic [RW-1:0] rep);
    logic got;
    got = 1'b0;
    bus.load_valid  = 1'b1;
    bus.load_data   = data;
    bus.load_repeat = rep;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.load_ready) got = 1'b1;
      step();
    end
    chk("accept", got, 1'b1);
    bus.load_valid  = 1'b0;
    bus.load_data   = W'($urandom);
    bus.load_repeat = RW'($urandom);
  endtask

  // Walks the whole burst from its first bit through DONE and the next IDLE.
  // mid_load raises a competing 8'hFF offer at bit 3 and leaves it held.
  task automatic expect_burst(input logic [W-1:0] data, input logic [RW-1:0] rep,
                              input logic mid_load);
    int n;
    n = W * (int'(rep) + 1);
    for (int i = 0; i < n; i++) begin
      chk_bit(data[W-1-(i % W)]);
      if (mid_load && i == 3) begin
        bus.load_valid  = 1'b1;
        bus.load_data   = 8'hFF;
        bus.load_repeat = '0;
      end
      step();
    end
    chk("done_pulse", {bus.load_ready, bus.busy, bus.done, bus.dout_valid, bus.dout}, 5'b00100);
`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
    chk("done_expect", bus.expect_out, 1'b0);
`endif
    step();
    chk_idle("after_done");
  endtask

  initial begin
    logic [W-1:0]  rd;
    logic [RW-1:0] rr;

    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_repeat = '0;
    exp_obs         = '0;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("idle");
    end

    // Single send
    accept(8'hB4, 4'd0);
    expect_burst(8'hB4, 4'd0, 1'b0);

    // Repeat, contiguous
    accept(8'h81, 4'd2);
    expect_burst(8'h81, 4'd2, 1'b0);

    // Load offered mid-burst is held off, then accepted right after IDLE
    accept(8'h3C, 4'd0);
    expect_burst(8'h3C, 4'd0, 1'b1);
    step();
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    expect_burst(8'hFF, 4'd0, 1'b0);

    // Reset mid-burst
    accept(8'hA5, 4'd0);
    for (int i = 0; i < 4; i++) begin
      chk_bit(8'hA5 >> (7 - i));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tx_q.delete();
    chk_idle("mid_reset");
    step();
    chk_idle("no_done_after_reset");
    accept(8'h0F, 4'd0);
    expect_burst(8'h0F, 4'd0, 1'b0);

`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
    do_reset();
    step();
    accept(8'b01101000, 4'd0);
    expect_burst(8'b01101000, 4'd0, 1'b0);
    chk("expect_seq", exp_obs, 8'b00111000);
`endif

    // Random bursts, one at maximum repeat count
    for (int k = 0; k < 8; k++) begin
      rd = W'($urandom);
      rr = (k == 3) ? {RW{1'b1}} : RW'($urandom_range(0, 3));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        chk_idle("gap");
        step();
      end
      accept(rd, rr);
      expect_burst(rd, rr, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
